rom_dl_sequencer: RTL and testbench
===================================

Name: rom_dl_sequencer

Overview:
- Sits between hps_io and the traverse_usa core, consuming the ioctl download stream.
- Routes index-0 ROM bytes to the core's dn_addr/dn_data/dn_wr port.
- Captures the game-variant byte (index 1) and the eight DIP bytes (index 254).
- Generates the core hold-reset and a ROM-ready flag through a small load state machine.

Parameters:
- ROM_BYTES, 98304: number of valid index-0 bytes; writes at or above this address are dropped.
- POST_CYCLES, 64: clk_sys cycles of held core reset after a successful ROM load ends (range 1..255).
- DIP_DEFAULT, 64'hFFFF_FFFF_FFFF_FFFF: reset value of dip_sw.

Ports:
- clk_sys  in  1  system clock (36 MHz).
- reset_n  in  1  synchronous reset, active-low.
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  8  download index.
- dn_addr  out  17  ROM write address to core.
- dn_data  out  8  ROM write data to core.
- dn_wr  out  1  ROM write strobe to core.
- mod_sel  out  8  game-variant byte (0 = Traverse USA, 1 = Shot Rider).
- dip_sw  out  64  DIP bytes; byte k is dip_sw[8k+7:8k].
- core_reset  out  1  active-high reset to core.
- rom_ready  out  1  ROM image loaded and post-hold complete.
- rom_overflow  out  1  sticky flag: an index-0 write was dropped.
- rom_bytes  out  17  count of accepted index-0 writes.
- rom_checksum  out  16  additive checksum (optional feature).

Behaviour:
- Reset (reset_n=0 at a clk_sys edge) values:
  - state=IDLE, dn_wr=0, dn_addr=0, dn_data=0.
  - mod_sel=0, dip_sw=DIP_DEFAULT.
  - core_reset=1, rom_ready=0, rom_overflow=0, rom_bytes=0, rom_checksum=0.
  - Reset mid-download discards all progress.
- States:
  - IDLE: ioctl_download=1 & ioctl_index=0 -> LOAD.
  - LOAD: ioctl_download=0 -> HOLD if rom_bytes!=0, else IDLE.
  - HOLD: counter loaded with POST_CYCLES-1 on entry, decrements each cycle; at 0 -> RUN.
  - RUN: ioctl_download=1 & ioctl_index=0 -> LOAD.
  - HOLD and RUN also take the index-0 entry to LOAD.
- On every entry to LOAD, in the same cycle: rom_bytes, rom_overflow, rom_checksum cleared and rom_ready cleared.
- rom_ready=1 only in RUN.
- core_reset is registered: 1 when state!=RUN or ioctl_download=1 (any index), on the previous cycle.
- ROM write path:
  - Condition: ioctl_wr=1 & ioctl_index=0 & ioctl_addr<ROM_BYTES, accepted in any state.
  - Effect: next cycle dn_wr=1 for exactly one cycle, dn_addr=ioctl_addr[16:0], dn_data=ioctl_dout, rom_bytes+1. Latency 1 cycle.
  - rom_bytes saturates at 2^17-1.
  - dn_addr/dn_data hold their last value when dn_wr=0.
- Overflow: index-0 write with ioctl_addr>=ROM_BYTES produces no dn_wr, no count, and sets rom_overflow. Sticky until next LOAD entry.
- Write and download-drop in the same cycle: the write is still accepted and emitted next cycle.
- Variant: ioctl_wr & ioctl_index=1 -> mod_sel<=ioctl_dout at any address; last byte wins. Takes effect next cycle.
- DIP: ioctl_wr & ioctl_index=254 & ioctl_addr[24:3]=0 -> dip byte ioctl_addr[2:0] <= ioctl_dout. Higher addresses ignored.
- Writes with other indices are ignored entirely.

Optional Feature:
- Macro: ROM_DL_CHECKSUM_EN.
- Defined: rom_checksum accumulates the 16-bit modular sum of every accepted index-0 byte (zero-extended). Updated with the dn_wr cycle; cleared on LOAD entry.
- Undefined: rom_checksum tied to 0, no accumulator logic.

Test Plan:
- Reset release, no stimulus -> core_reset=1, rom_ready=0, dip_sw=all FF, mod_sel=0, dn_wr never asserts.
- Index-0 download of 4 bytes (addr 0..3, data 01,02,03,04), then drop download:
  - Each dn_wr appears 1 cycle after its ioctl_wr with the matching addr/data; rom_bytes=4.
  - rom_ready=1 and core_reset=0 after exactly POST_CYCLES cycles of HOLD.
  - With ROM_DL_CHECKSUM_EN, rom_checksum=0x000A.
- Index-0 write at addr 98304 (data 55) -> no dn_wr, rom_overflow=1. Next index-0 download start -> rom_overflow=0.
- Index-254 writes addr 0=0x3C, addr 1=0xA5, addr 8=0x00 -> dip_sw[7:0]=3C, dip_sw[15:8]=A5, all other bytes FF. Index-1 write 0x01 -> mod_sel=01.
- Index-0 download with zero writes -> returns to IDLE, rom_ready stays 0, core_reset stays 1.
- reset_n low for 1 cycle mid-LOAD after 2 writes -> rom_bytes=0, state IDLE, dip_sw=FF..FF, no dn_wr for pending data.

Source files
------------

// File: rtl/rom_dl_sequencer.sv
// -----------------------------------------------------------------------------
// rom_dl_sequencer
// Sits between hps_io and the traverse_usa core. It consumes the ioctl
// download stream, forwards index-0 ROM bytes to the core's dn_* write port,
// captures the game-variant byte (index 1) and the eight DIP bytes
// (index 254), and sequences the core hold-reset / ROM-ready flag through a
// small load state machine (IDLE -> LOAD -> HOLD -> RUN).
//
// Optional feature macro: ROM_DL_CHECKSUM_EN
//   defined   : rom_checksum is the 16-bit modular sum of accepted ROM bytes
//   undefined : rom_checksum is tied to zero
//
// Ports:
//   clk_sys        in   1   system clock
//   reset_n        in   1   synchronous reset, active-low
//   ioctl_download in   1   download in progress
//   ioctl_wr       in   1   byte strobe
//   ioctl_addr     in  25   byte address
//   ioctl_dout     in   8   byte data
//   ioctl_index    in   8   download index
//   dn_addr        out 17   ROM write address to core
//   dn_data        out  8   ROM write data to core
//   dn_wr          out  1   ROM write strobe to core (one cycle per byte)
//   mod_sel        out  8   game-variant byte
//   dip_sw         out 64   DIP bytes, byte k at [8k+7:8k]
//   core_reset     out  1   active-high reset to core
//   rom_ready      out  1   ROM loaded and post-load hold complete
//   rom_overflow   out  1   sticky: an index-0 write beyond ROM_BYTES was dropped
//   rom_bytes      out 17   count of accepted index-0 writes (saturating)
//   rom_checksum   out 16   additive checksum of accepted ROM bytes
// -----------------------------------------------------------------------------
module rom_dl_sequencer #(
    parameter int unsigned ROM_BYTES   = 98304,
    parameter int unsigned POST_CYCLES = 64,
    parameter logic [63:0] DIP_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic [16:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [7:0]  mod_sel,
    output logic [63:0] dip_sw,
    output logic        core_reset,
    output logic        rom_ready,
    output logic        rom_overflow,
    output logic [16:0] rom_bytes,
    output logic [15:0] rom_checksum
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam logic [24:0] ROM_LIMIT_C = 25'(ROM_BYTES);
    localparam logic [7:0]  HOLD_INIT_C = 8'(POST_CYCLES - 1);
    localparam logic [16:0] BYTES_MAX_C = 17'h1FFFF;

    state_t          state_r, state_s;
    logic [7:0]      hold_cnt_r, hold_cnt_s;
    logic [16:0]     dn_addr_r;
    logic [7:0]      dn_data_r;
    logic            dn_wr_r;
    logic [7:0]      mod_sel_r;
    logic [7:0][7:0] dip_r;
    logic            core_reset_r;
    logic            rom_ready_r;
    logic            rom_overflow_r;
    logic [16:0]     rom_bytes_r;

    logic idx0_s, rom_start_s, rom_acc_s, rom_drop_s, load_entry_s;

    assign idx0_s       = (ioctl_index == 8'd0);
    assign rom_start_s  = ioctl_download & idx0_s;
    assign rom_acc_s    = ioctl_wr & idx0_s & (ioctl_addr <  ROM_LIMIT_C);
    assign rom_drop_s   = ioctl_wr & idx0_s & (ioctl_addr >= ROM_LIMIT_C);
    // Entry is detected on the transition so status clears on the same edge
    // the state register moves into LOAD.
    assign load_entry_s = (state_s == ST_LOAD) && (state_r != ST_LOAD);

    // Next-state and hold-counter logic for the load sequencer.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (rom_start_s) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!ioctl_download) begin
                    if (rom_bytes_r != 17'd0) begin
                        state_s    = ST_HOLD;
                        hold_cnt_s = HOLD_INIT_C;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_HOLD: begin
                if (rom_start_s) begin
                    state_s = ST_LOAD;
                end else if (hold_cnt_r == 8'd0) begin
                    state_s = ST_RUN;
                end else begin
                    hold_cnt_s = hold_cnt_r - 8'd1;
                end
            end
            ST_RUN: begin
                if (rom_start_s) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                hold_cnt_s = 8'd0;
            end
        endcase
    end

    // State and hold-counter registers.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_cnt_s;
        end
    end

    // ROM write path: one-cycle registered forward of accepted index-0 bytes.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dn_wr_r   <= 1'b0;
            dn_addr_r <= 17'd0;
            dn_data_r <= 8'd0;
        end else begin
            dn_wr_r <= rom_acc_s;
            if (rom_acc_s) begin
                dn_addr_r <= ioctl_addr[16:0];
                dn_data_r <= ioctl_dout;
            end
        end
    end

    // Load status: byte count, overflow flag, ready flag and core reset.
    // A write landing on the LOAD-entry edge belongs to the new load.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rom_bytes_r    <= 17'd0;
            rom_overflow_r <= 1'b0;
            rom_ready_r    <= 1'b0;
            core_reset_r   <= 1'b1;
        end else begin
            if (load_entry_s) begin
                rom_bytes_r    <= rom_acc_s ? 17'd1 : 17'd0;
                rom_overflow_r <= rom_drop_s;
            end else begin
                if (rom_acc_s && (rom_bytes_r != BYTES_MAX_C)) begin
                    rom_bytes_r <= rom_bytes_r + 17'd1;
                end
                if (rom_drop_s) begin
                    rom_overflow_r <= 1'b1;
                end
            end
            rom_ready_r  <= (state_s == ST_RUN);
            core_reset_r <= (state_r != ST_RUN) | ioctl_download;
        end
    end

    // Variant and DIP capture from indices 1 and 254.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            mod_sel_r <= 8'd0;
            dip_r     <= DIP_DEFAULT;
        end else begin
            if (ioctl_wr && (ioctl_index == 8'd1)) begin
                mod_sel_r <= ioctl_dout;
            end
            if (ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0)) begin
                dip_r[ioctl_addr[2:0]] <= ioctl_dout;
            end
        end
    end

`ifdef ROM_DL_CHECKSUM_EN
    function automatic logic [15:0] csum_add(input logic [15:0] sum, input logic [7:0] data);
        return sum + {8'h00, data};
    endfunction

    logic [15:0] checksum_r;

    // Additive checksum, updated on the same edge that raises dn_wr.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            checksum_r <= 16'd0;
        end else if (load_entry_s) begin
            checksum_r <= rom_acc_s ? {8'h00, ioctl_dout} : 16'd0;
        end else if (rom_acc_s) begin
            checksum_r <= csum_add(checksum_r, ioctl_dout);
        end
    end

    assign rom_checksum = checksum_r;
`else
    assign rom_checksum = 16'h0000;
`endif

    assign dn_addr      = dn_addr_r;
    assign dn_data      = dn_data_r;
    assign dn_wr        = dn_wr_r;
    assign mod_sel      = mod_sel_r;
    assign dip_sw       = dip_r;
    assign core_reset   = core_reset_r;
    assign rom_ready    = rom_ready_r;
    assign rom_overflow = rom_overflow_r;
    assign rom_bytes    = rom_bytes_r;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rom_dl_sequencer
// Directed self-checking bench for rom_dl_sequencer with default parameters.
// Inputs are driven and outputs sampled on the falling edge of clk_sys.
// -----------------------------------------------------------------------------
module tb_rom_dl_sequencer;

    localparam int P_CYC = 64;

    logic        clk_sys;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic [16:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [7:0]  mod_sel;
    logic [63:0] dip_sw;
    logic        core_reset;
    logic        rom_ready;
    logic        rom_overflow;
    logic [16:0] rom_bytes;
    logic [15:0] rom_checksum;

    int n_checks = 0;
    int n_errors = 0;
    int dn_wr_seen = 0;

    rom_dl_sequencer dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .mod_sel        (mod_sel),
        .dip_sw         (dip_sw),
        .core_reset     (core_reset),
        .rom_ready      (rom_ready),
        .rom_overflow   (rom_overflow),
        .rom_bytes      (rom_bytes),
        .rom_checksum   (rom_checksum)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Count dn_wr pulses; each pulse is one cycle wide so one falling edge sees it.
    always @(negedge clk_sys) begin
        if (dn_wr === 1'b1) begin
            dn_wr_seen <= dn_wr_seen + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // One-cycle byte strobe; call at a falling edge, returns one edge later.
    task automatic write_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = data;
        ioctl_wr    = 1'b1;
        @(negedge clk_sys);
        ioctl_wr    = 1'b0;
    endtask

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'd0;
        ioctl_index    = 8'd0;
        step(3);
        reset_n = 1'b1;
        step(5);

        // Reset state with no stimulus
        check_eq("rst_core_reset", 64'(core_reset), 64'd1);
        check_eq("rst_rom_ready", 64'(rom_ready), 64'd0);
        check_eq("rst_dip_sw", dip_sw, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("rst_mod_sel", 64'(mod_sel), 64'd0);
        check_eq("rst_rom_bytes", 64'(rom_bytes), 64'd0);
        check_eq("rst_overflow", 64'(rom_overflow), 64'd0);
        check_eq("rst_dn_addr", 64'(dn_addr), 64'd0);
        check_eq("rst_checksum", 64'(rom_checksum), 64'd0);
        check_eq("rst_dn_wr_seen", 64'(dn_wr_seen), 64'd0);

        // Four-byte index-0 load
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        step(1);
        check_eq("load_core_reset", 64'(core_reset), 64'd1);
        for (int i = 0; i < 4; i++) begin
            write_byte(8'd0, 25'(i), 8'(i + 1));
            check_eq("load_dn_wr", 64'(dn_wr), 64'd1);
            check_eq("load_dn_addr", 64'(dn_addr), 64'(i));
            check_eq("load_dn_data", 64'(dn_data), 64'(i + 1));
        end
        step(1);
        check_eq("load_dn_wr_low", 64'(dn_wr), 64'd0);
        check_eq("load_dn_addr_hold", 64'(dn_addr), 64'd3);
        check_eq("load_rom_bytes", 64'(rom_bytes), 64'd4);
        check_eq("load_dn_wr_seen", 64'(dn_wr_seen), 64'd4);
`ifdef ROM_DL_CHECKSUM_EN
        check_eq("load_checksum", 64'(rom_checksum), 64'h000A);
`else
        check_eq("load_checksum", 64'(rom_checksum), 64'h0000);
`endif

        // Post-load hold of exactly P_CYC cycles
        ioctl_download = 1'b0;
        step(P_CYC);
        check_eq("hold_ready_early", 64'(rom_ready), 64'd0);
        check_eq("hold_core_reset", 64'(core_reset), 64'd1);
        step(1);
        check_eq("run_ready", 64'(rom_ready), 64'd1);
        check_eq("run_core_reset_lag", 64'(core_reset), 64'd1);
        step(1);
        check_eq("run_core_reset", 64'(core_reset), 64'd0);
        check_eq("run_ready_stay", 64'(rom_ready), 64'd1);

        // Overflow boundary and clearing on next load
        write_byte(8'd0, 25'd98304, 8'h55);
        check_eq("ovf_dn_wr", 64'(dn_wr), 64'd0);
        check_eq("ovf_flag", 64'(rom_overflow), 64'd1);
        check_eq("ovf_rom_bytes", 64'(rom_bytes), 64'd4);
        write_byte(8'd0, 25'd98303, 8'h77);
        check_eq("edge_dn_wr", 64'(dn_wr), 64'd1);
        check_eq("edge_dn_addr", 64'(dn_addr), 64'h17FFF);
        check_eq("edge_dn_data", 64'(dn_data), 64'h77);
        check_eq("edge_rom_bytes", 64'(rom_bytes), 64'd5);
        check_eq("edge_ovf_sticky", 64'(rom_overflow), 64'd1);
        step(1);
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        step(1);
        check_eq("reload_ovf_clear", 64'(rom_overflow), 64'd0);
        check_eq("reload_bytes_clear", 64'(rom_bytes), 64'd0);
        check_eq("reload_ready_clear", 64'(rom_ready), 64'd0);
        check_eq("reload_checksum", 64'(rom_checksum), 64'd0);
        check_eq("reload_core_reset", 64'(core_reset), 64'd1);

        // Empty download returns to IDLE
        ioctl_download = 1'b0;
        step(P_CYC + 16);
        check_eq("empty_ready", 64'(rom_ready), 64'd0);
        check_eq("empty_core_reset", 64'(core_reset), 64'd1);
        check_eq("empty_dn_wr_seen", 64'(dn_wr_seen), 64'd5);

        // DIP and variant capture
        write_byte(8'd254, 25'd0, 8'h3C);
        write_byte(8'd254, 25'd1, 8'hA5);
        write_byte(8'd254, 25'd8, 8'h00);
        check_eq("dip_sw", dip_sw, 64'hFFFF_FFFF_FFFF_A53C);
        write_byte(8'd1, 25'd5, 8'h07);
        check_eq("mod_sel_first", 64'(mod_sel), 64'h07);
        write_byte(8'd1, 25'd0, 8'h01);
        check_eq("mod_sel_last", 64'(mod_sel), 64'h01);
        write_byte(8'd2, 25'd0, 8'h99);
        check_eq("other_idx_dip", dip_sw, 64'hFFFF_FFFF_FFFF_A53C);
        check_eq("other_idx_mod", 64'(mod_sel), 64'h01);
        check_eq("other_idx_dn_wr", 64'(dn_wr), 64'd0);

        // Reset mid-load after two writes, with a third write pending
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        step(1);
        write_byte(8'd0, 25'd0, 8'hAA);
        write_byte(8'd0, 25'd1, 8'hBB);
        check_eq("mid_rom_bytes", 64'(rom_bytes), 64'd2);
        ioctl_addr = 25'd2;
        ioctl_dout = 8'hCC;
        ioctl_wr   = 1'b1;
        reset_n    = 1'b0;
        step(1);
        ioctl_wr       = 1'b0;
        reset_n        = 1'b1;
        ioctl_download = 1'b0;
        check_eq("mrst_dn_wr", 64'(dn_wr), 64'd0);
        check_eq("mrst_rom_bytes", 64'(rom_bytes), 64'd0);
        check_eq("mrst_dip_sw", dip_sw, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("mrst_mod_sel", 64'(mod_sel), 64'd0);
        check_eq("mrst_dn_addr", 64'(dn_addr), 64'd0);
        step(P_CYC + 4);
        check_eq("mrst_ready", 64'(rom_ready), 64'd0);
        check_eq("mrst_core_reset", 64'(core_reset), 64'd1);
        check_eq("mrst_dn_wr_seen", 64'(dn_wr_seen), 64'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
